// File: rtl/vip_ext_port_arbiter_if.sv
// Bus bundle for vip_ext_port_arbiter: NumPorts upstream request/response ports
// plus the single muxed downstream port. The arbiter uses the slave modport.
interface vip_ext_port_arbiter_if #(
   parameter int NumPorts     = 4,
   parameter int AddrWidth    = 48,
   parameter int DataWidth    = 64,
   parameter int IdWidth      = 4,
   parameter int PortIdxWidth = $clog2(NumPorts)
);
   logic [NumPorts-1:0]              slv_req_valid_i;
   logic [NumPorts-1:0]              slv_req_ready_o;
   logic [NumPorts*AddrWidth-1:0]    slv_req_addr_i;
   logic [NumPorts-1:0]              slv_req_we_i;
   logic [NumPorts*DataWidth-1:0]    slv_req_wdata_i;
   logic [NumPorts*IdWidth-1:0]      slv_req_id_i;
   logic [NumPorts-1:0]              slv_rsp_valid_o;
   logic [NumPorts-1:0]              slv_rsp_ready_i;
   logic [DataWidth-1:0]             slv_rsp_rdata_o;
   logic [IdWidth-1:0]               slv_rsp_id_o;
   logic                             slv_rsp_err_o;
   logic                             mst_req_valid_o;
   logic                             mst_req_ready_i;
   logic [AddrWidth-1:0]             mst_req_addr_o;
   logic                             mst_req_we_o;
   logic [DataWidth-1:0]             mst_req_wdata_o;
   logic [PortIdxWidth+IdWidth-1:0]  mst_req_id_o;
   logic                             mst_rsp_valid_i;
   logic                             mst_rsp_ready_o;
   logic [DataWidth-1:0]             mst_rsp_rdata_i;
   logic                             mst_rsp_err_i;
   logic [PortIdxWidth+IdWidth-1:0]  mst_rsp_id_i;

   modport slave (
      input  slv_req_valid_i, slv_req_addr_i, slv_req_we_i, slv_req_wdata_i, slv_req_id_i,
      input  slv_rsp_ready_i, mst_req_ready_i,
      input  mst_rsp_valid_i, mst_rsp_rdata_i, mst_rsp_err_i, mst_rsp_id_i,
      output slv_req_ready_o, slv_rsp_valid_o, slv_rsp_rdata_o, slv_rsp_id_o, slv_rsp_err_o,
      output mst_req_valid_o, mst_req_addr_o, mst_req_we_o, mst_req_wdata_o, mst_req_id_o,
      output mst_rsp_ready_o
   );

   modport master (
      output slv_req_valid_i, slv_req_addr_i, slv_req_we_i, slv_req_wdata_i, slv_req_id_i,
      output slv_rsp_ready_i, mst_req_ready_i,
      output mst_rsp_valid_i, mst_rsp_rdata_i, mst_rsp_err_i, mst_rsp_id_i,
      input  slv_req_ready_o, slv_rsp_valid_o, slv_rsp_rdata_o, slv_rsp_id_o, slv_rsp_err_o,
      input  mst_req_valid_o, mst_req_addr_o, mst_req_we_o, mst_req_wdata_o, mst_req_id_o,
      input  mst_rsp_ready_o
   );
endinterface

// File: rtl/vip_ext_port_arbiter.sv
// N-to-1 request arbiter with ID prefixing, prefix-routed responses and per-port
// outstanding limits. Define VIP_ARB_STATS_EN to add per-port grant counters.
module vip_ext_port_arbiter #(
   parameter int NumPorts       = 4,
   parameter int AddrWidth      = 48,
   parameter int DataWidth      = 64,
   parameter int IdWidth        = 4,
   parameter int MaxOutstanding = 8,
   parameter int ArbMode        = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   vip_ext_port_arbiter_if.slave  bus,
`ifdef VIP_ARB_STATS_EN
   output logic [NumPorts*32-1:0] stat_grants_o,
`endif
   output logic                   misroute_o
);

   localparam int PortIdxWidth = $clog2(NumPorts);
   localparam int CntWidth     = $clog2(MaxOutstanding + 1);
   localparam int MstIdWidth   = PortIdxWidth + IdWidth;

   typedef logic [PortIdxWidth-1:0] idx_t;
   typedef logic [CntWidth-1:0]     cnt_t;

   logic [NumPorts-1:0]   elig, req_ready, req_hs, rsp_valid, rsp_hs;
   idx_t                  ptr_q, ptr_d, grant_idx, rsp_prefix;
   logic                  grant_valid, load, rsp_ready;
   logic                  slot_valid_q, slot_we_q, sel_we, misroute_q;
   logic [AddrWidth-1:0]  slot_addr_q, sel_addr;
   logic [DataWidth-1:0]  slot_wdata_q, sel_wdata;
   logic [IdWidth-1:0]    sel_id;
   logic [MstIdWidth-1:0] slot_id_q;

   assign load = !slot_valid_q || bus.mst_req_ready_i;

   for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
      cnt_t cnt_q, cnt_d;

      assign elig[gi]      = bus.slv_req_valid_i[gi] && (cnt_q < cnt_t'(MaxOutstanding));
      assign req_ready[gi] = load && grant_valid && (grant_idx == idx_t'(gi));
      assign req_hs[gi]    = req_ready[gi] && bus.slv_req_valid_i[gi];

      // Simultaneous issue and retire cancel; a stray retire at zero saturates.
      always_comb begin
         cnt_d = cnt_q;
         if (req_hs[gi] && !rsp_hs[gi])
            cnt_d = cnt_q + cnt_t'(1);
         else if (rsp_hs[gi] && !req_hs[gi] && cnt_q != '0)
            cnt_d = cnt_q - cnt_t'(1);
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) cnt_q <= '0;
         else       cnt_q <= cnt_d;
      end
   end

   if (ArbMode == 1) begin : g_fixed
      always_comb begin
         grant_valid = 1'b0;
         grant_idx   = '0;
         for (int p = NumPorts - 1; p >= 0; p--) begin
            if (elig[p]) begin
               grant_valid = 1'b1;
               grant_idx   = idx_t'(p);
            end
         end
      end
   end else begin : g_rr
      int cand;
      // Scan from the far end so the candidate closest to the pointer wins.
      always_comb begin
         grant_valid = 1'b0;
         grant_idx   = '0;
         cand        = 0;
         for (int k = NumPorts - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NumPorts) cand = cand - NumPorts;
            if (elig[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = idx_t'(cand);
            end
         end
      end
   end

   assign ptr_d = (grant_idx == idx_t'(NumPorts - 1)) ? '0 : grant_idx + idx_t'(1);

   always_comb begin
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_wdata = '0;
      sel_id    = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (grant_idx == idx_t'(p)) begin
            sel_addr  = bus.slv_req_addr_i[p*AddrWidth +: AddrWidth];
            sel_we    = bus.slv_req_we_i[p];
            sel_wdata = bus.slv_req_wdata_i[p*DataWidth +: DataWidth];
            sel_id    = bus.slv_req_id_i[p*IdWidth +: IdWidth];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_valid_q <= 1'b0;
         ptr_q        <= '0;
         misroute_q   <= 1'b0;
      end else begin
         if (load) begin
            slot_valid_q <= grant_valid;
            if (grant_valid) begin
               slot_addr_q  <= sel_addr;
               slot_we_q    <= sel_we;
               slot_wdata_q <= sel_wdata;
               slot_id_q    <= {grant_idx, sel_id};
               if (ArbMode == 0) ptr_q <= ptr_d;
            end
         end
         if (bus.mst_rsp_valid_i && (rsp_valid == '0)) misroute_q <= 1'b1;
      end
   end

   // Unmatched prefixes leave rsp_valid empty and are accepted so the bus never stalls.
   assign rsp_prefix = bus.mst_rsp_id_i[IdWidth +: PortIdxWidth];
   always_comb begin
      rsp_valid = '0;
      rsp_ready = 1'b1;
      for (int p = 0; p < NumPorts; p++) begin
         if (rsp_prefix == idx_t'(p)) begin
            rsp_valid[p] = bus.mst_rsp_valid_i;
            rsp_ready    = bus.slv_rsp_ready_i[p];
         end
      end
   end
   assign rsp_hs = rsp_valid & bus.slv_rsp_ready_i;

   assign bus.slv_req_ready_o = req_ready;
   assign bus.slv_rsp_valid_o = rsp_valid;
   assign bus.slv_rsp_rdata_o = bus.mst_rsp_rdata_i;
   assign bus.slv_rsp_id_o    = bus.mst_rsp_id_i[IdWidth-1:0];
   assign bus.slv_rsp_err_o   = bus.mst_rsp_err_i;
   assign bus.mst_rsp_ready_o = rsp_ready;
   assign bus.mst_req_valid_o = slot_valid_q;
   assign bus.mst_req_addr_o  = slot_addr_q;
   assign bus.mst_req_we_o    = slot_we_q;
   assign bus.mst_req_wdata_o = slot_wdata_q;
   assign bus.mst_req_id_o    = slot_id_q;
   assign misroute_o          = misroute_q;

`ifdef VIP_ARB_STATS_EN
   for (genvar gi = 0; gi < NumPorts; gi++) begin : g_stats
      logic [31:0] grants_q;
      always_ff @(posedge clk_i) begin
         if (rst_i)           grants_q <= '0;
         else if (req_hs[gi]) grants_q <= grants_q + 32'd1;
      end
      assign stat_grants_o[gi*32 +: 32] = grants_q;
   end
`endif

endmodule

// File: doc/vip_ext_port_arbiter.md
Name: vip_ext_port_arbiter

Overview:
Parametrised N-to-1 request/response arbiter for simulation VIP traffic. It merges NumPorts external virtual master ports onto one muxed master port, prefixes each ID with the source port index, and routes responses back by that prefix. It is the successor of the fixed AXI mux + ID-remap pair in the SoC VIP. It adds selectable arbitration mode, per-port outstanding-transaction limiting, and misrouted-response detection.

Parameters:
NumPorts, 4, number of upstream ports (>=2)
AddrWidth, 48, request address width
DataWidth, 64, write/read data width
IdWidth, 4, upstream ID width
MaxOutstanding, 8, max in-flight requests per port (>=1)
ArbMode, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
PortIdxWidth, $clog2(NumPorts), derived; do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
slv_req_valid_i  in  NumPorts  per-port request valid
slv_req_ready_o  out  NumPorts  per-port request ready
slv_req_addr_i  in  NumPorts*AddrWidth  request address
slv_req_we_i  in  NumPorts  1 = write
slv_req_wdata_i  in  NumPorts*DataWidth  write data
slv_req_id_i  in  NumPorts*IdWidth  request ID
slv_rsp_valid_o  out  NumPorts  per-port response valid
slv_rsp_ready_i  in  NumPorts  per-port response ready
slv_rsp_rdata_o  out  DataWidth  response data (broadcast; qualified by valid)
slv_rsp_id_o  out  IdWidth  response ID with prefix stripped (broadcast)
slv_rsp_err_o  out  1  response error (broadcast)
mst_req_valid_o  out  1  muxed request valid
mst_req_ready_i  in  1  muxed request ready
mst_req_addr_o / mst_req_we_o / mst_req_wdata_o  out  AddrWidth / 1 / DataWidth  muxed request payload
mst_req_id_o  out  PortIdxWidth+IdWidth  {port index, upstream ID}
mst_rsp_valid_i  in  1  muxed response valid
mst_rsp_ready_o  out  1  muxed response ready
mst_rsp_rdata_i / mst_rsp_err_i  in  DataWidth / 1  response payload
mst_rsp_id_i  in  PortIdxWidth+IdWidth  response ID
misroute_o  out  1  sticky: response with prefix >= NumPorts seen

Behaviour:
- Reset (rst_i high at clk_i edge): mst_req_valid_o=0, all outstanding counters=0, RR pointer=0, misroute_o=0. slv_rsp_valid_o=0 follows because mst_rsp_valid_i gating is combinational.
- Eligible port p: slv_req_valid_i[p]=1 and cnt[p] < MaxOutstanding.
- Request path uses a single registered output slot.
  - Slot is loaded when it is empty, or when it is draining this cycle (mst_req_valid_o & mst_req_ready_i).
  - On load, the winner gets slv_req_ready_o[p]=1 (combinational). All other ports get ready=0.
  - Latency from upstream handshake to mst_req_valid_o is 1 cycle. Throughput is 1 request/cycle.
  - While mst_req_valid_o=1 and mst_req_ready_i=0, the payload and ID are held stable.
- Round-robin: search starts at the RR pointer. After a grant to port p, the pointer becomes (p+1) mod NumPorts. The pointer is unchanged when there is no grant.
- Fixed priority: the lowest-index eligible port wins.
- cnt[p] increments on the upstream request handshake of p. It decrements on the downstream response handshake with prefix p. If both happen in the same cycle, cnt[p] is unchanged. cnt[p] never exceeds MaxOutstanding; at that value the port is masked.
- Response path is combinational (zero latency).
  - Prefix k < NumPorts: slv_rsp_valid_o[k]=mst_rsp_valid_i and mst_rsp_ready_o=slv_rsp_ready_i[k].
  - Prefix k >= NumPorts (non-power-of-2 NumPorts): mst_rsp_ready_o=1, the response is dropped, and misroute_o is set until reset. No counter changes.
- Response at prefix p while cnt[p]==0 is a protocol error: the counter saturates at 0 and the response is still forwarded. There is no simulation assertion in this case.
- Reset mid-transaction drops the slot contents and counters. The upstream and downstream VIPs are reset together.

Optional Feature:
VIP_ARB_STATS_EN: when defined, adds output stat_grants_o (NumPorts*32).
- Each field is a per-port grant counter: +1 on each upstream handshake, wraps at 2^32, cleared by rst_i.
- When not defined, the port is absent and no counter logic is built.

Test Plan:
- ArbMode=0, all 4 ports valid continuously, mst_req_ready_i=1 -> grants 0,1,2,3,0,... one per cycle. First mst_req_valid_o appears 1 cycle after the first handshake.
- ArbMode=1, ports 1 and 3 valid -> port 1 granted every cycle and port 3 starved. Drop port 1 -> port 3 granted the next cycle.
- MaxOutstanding=2, port 0 only, no responses -> exactly 2 handshakes, then slv_req_ready_o[0]=0. One response with ID {0,5} -> slv_rsp_id_o=5, a third grant follows, and cnt stays 2.
- mst_req_ready_i=0 for 5 cycles with slot full -> payload and mst_req_id_o stable, no upstream ready asserted. Ready=1 -> drain and reload in the same cycle.
- NumPorts=3, response with prefix 3 -> mst_rsp_ready_o=1, no slv_rsp_valid_o asserted, misroute_o=1 held until rst_i.
- Same-cycle request handshake and response for port 2 at cnt=1 -> cnt remains 1. Assert rst_i mid-stall -> mst_req_valid_o=0 the next cycle and all counters 0.
